side_road_detector: RTL and testbench

//  Vehicle-presence front end for the side-road approach: produces the car-sensor input C

---
 rtl/side_road_detector.sv | 160 ++++++++++++++++
 tb/tb_side_road_detector.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/side_road_detector.sv
// Side-road vehicle presence: two synchronised, debounced loop inputs drive a saturating queue count and C.
// Optional stuck-loop clear is built when TRAFFIC_STUCK_CLR_EN is defined.

// state     | meaning
// IDLE      | accepted level low, synced input agrees
// RISE_WAIT | synced input high, counting toward acceptance
// ACTIVE    | accepted level high (vehicle on loop)
// FALL_WAIT | synced input low, counting toward release
module side_road_debounce #(
   parameter int DEBOUNCE = 3
) (
   input  logic Clk,
   input  logic reset,
   input  logic raw_i,
   output logic event_o
);
   localparam int CW = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

   typedef enum logic [1:0] {IDLE, RISE_WAIT, ACTIVE, FALL_WAIT} state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [1:0]    sync_q;
   logic          s_w;

   assign s_w = sync_q[1];
   // Decoded from current state so the queue updates on the very edge ACTIVE is entered.
   assign event_o = (state_q == RISE_WAIT) && s_w && (cnt_q == CNT_LAST);

   always_ff @(posedge Clk) begin
      if (reset) begin
         sync_q  <= 2'b00;
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         sync_q <= {sync_q[0], raw_i};
         case (state_q)
            IDLE: begin
               if (s_w) begin
                  state_q <= RISE_WAIT;
                  cnt_q   <= CW'(1);
               end
            end
            RISE_WAIT: begin
               if (!s_w)                  state_q <= IDLE;
               else if (cnt_q == CNT_LAST) state_q <= ACTIVE;
               else                       cnt_q   <= cnt_q + CW'(1);
            end
            ACTIVE: begin
               if (!s_w) begin
                  state_q <= FALL_WAIT;
                  cnt_q   <= CW'(1);
               end
            end
            FALL_WAIT: begin
               if (s_w)                   state_q <= ACTIVE;
               else if (cnt_q == CNT_LAST) state_q <= IDLE;
               else                       cnt_q   <= cnt_q + CW'(1);
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

module side_road_detector #(
   parameter int DEBOUNCE     = 3,
   parameter int CNT_W        = 4,
   parameter int MAX_Q        = 15,
   parameter int STUCK_CYCLES = 32
) (
   input  logic             Clk,
   input  logic             reset,
   input  logic             loop_in,
   input  logic             exit_in,
   input  logic             SG,
   output logic             C,
   output logic [CNT_W-1:0] queue,
   output logic             err,
   output logic             fault
);
   localparam logic [CNT_W-1:0] Q_MAX = CNT_W'(MAX_Q);

   logic             arr_w, ext_w;
   logic [CNT_W-1:0] queue_q, queue_d;
   logic             c_q, err_q, err_set;

   side_road_debounce #(.DEBOUNCE(DEBOUNCE)) u_arr (
      .Clk(Clk), .reset(reset), .raw_i(loop_in), .event_o(arr_w));
   side_road_debounce #(.DEBOUNCE(DEBOUNCE)) u_ext (
      .Clk(Clk), .reset(reset), .raw_i(exit_in), .event_o(ext_w));

`ifdef TRAFFIC_STUCK_CLR_EN
   localparam int TW = (STUCK_CYCLES > 1) ? $clog2(STUCK_CYCLES) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(STUCK_CYCLES - 1);

   logic [TW-1:0] timer_q, timer_d;
   logic          fault_q, stuck_inc, stuck_fire;

   assign stuck_inc  = SG && (queue_q != '0) && !ext_w;
   assign stuck_fire = stuck_inc && (timer_q == T_LAST);

   always_comb begin
      timer_d = '0;
      if (stuck_inc && !stuck_fire) timer_d = timer_q + TW'(1);
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         timer_q <= '0;
         fault_q <= 1'b0;
      end else begin
         timer_q <= timer_d;
         if (stuck_fire) fault_q <= 1'b1;
      end
   end

   assign fault = fault_q;
`else
   logic unused_cfg;
   assign unused_cfg = SG & (STUCK_CYCLES > 0);
   assign fault      = 1'b0;
`endif

   // Simultaneous arrival and exit cancel, even at the saturation limits.
   always_comb begin
      queue_d = queue_q;
      err_set = 1'b0;
      if (arr_w && !ext_w) begin
         if (queue_q == Q_MAX) err_set = 1'b1;
         else                  queue_d = queue_q + CNT_W'(1);
      end else if (ext_w && !arr_w) begin
         if (queue_q == '0)    err_set = 1'b1;
         else                  queue_d = queue_q - CNT_W'(1);
      end
`ifdef TRAFFIC_STUCK_CLR_EN
      if (stuck_fire) begin
         queue_d = '0;
         err_set = 1'b0;
      end
`endif
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         queue_q <= '0;
         c_q     <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         queue_q <= queue_d;
         c_q     <= (queue_d != '0);
         if (err_set) err_q <= 1'b1;
      end
   end

   assign queue = queue_q;
   assign C     = c_q;
   assign err   = err_q;
endmodule

// File: tb/tb_side_road_detector.sv
// Directed and randomized check of side_road_detector against a level-acceptance reference model.
module tb_side_road_detector;
   localparam int D     = 3;
   localparam int MAXQ  = 15;
   localparam int STUCK = 32;

   logic       Clk = 1'b0;
   logic       reset, loop_in, exit_in, SG;
   logic       C, err, fault;
   logic [3:0] queue;

   int total = 0;
   int bad   = 0;

   // Reference: raw samples delayed two edges, then a level is accepted after D disagreeing samples.
   bit m_hist [2][2];
   bit m_lvl  [2];
   int m_run  [2];
   int m_q, m_timer;
   bit m_err, m_fault;

   always #5 Clk = ~Clk;

   side_road_detector dut (
      .Clk(Clk), .reset(reset), .loop_in(loop_in), .exit_in(exit_in), .SG(SG),
      .C(C), .queue(queue), .err(err), .fault(fault));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic accept(input int ch, input bit s, output bit ev);
      ev = 1'b0;
      if (s != m_lvl[ch]) begin
         m_run[ch]++;
         if (m_run[ch] == D) begin
            m_lvl[ch] = s;
            m_run[ch] = 0;
            ev        = s;
         end
      end else begin
         m_run[ch] = 0;
      end
   endtask

   task automatic model_edge(input bit r, input bit l, input bit e, input bit sg);
      bit arr, ext, inc, fire;
      if (r) begin
         for (int c = 0; c < 2; c++) begin
            m_hist[c][0] = 0; m_hist[c][1] = 0; m_lvl[c] = 0; m_run[c] = 0;
         end
         m_q = 0; m_timer = 0; m_err = 0; m_fault = 0;
      end else begin
         accept(0, m_hist[0][1], arr);
         accept(1, m_hist[1][1], ext);
         m_hist[0][1] = m_hist[0][0]; m_hist[0][0] = l;
         m_hist[1][1] = m_hist[1][0]; m_hist[1][0] = e;
         inc = sg && (m_q != 0) && !ext;
`ifdef TRAFFIC_STUCK_CLR_EN
         fire = inc && (m_timer == STUCK - 1);
`else
         fire = 1'b0;
`endif
         m_timer = fire ? 0 : (inc ? m_timer + 1 : 0);
         if (fire) begin
            m_q = 0; m_fault = 1;
         end else if (arr && !ext) begin
            if (m_q == MAXQ) m_err = 1; else m_q++;
         end else if (ext && !arr) begin
            if (m_q == 0) m_err = 1; else m_q--;
         end
      end
   endtask

   task automatic tick(input bit l, input bit e, input bit sg, input bit r);
      loop_in = l; exit_in = e; SG = sg; reset = r;
      @(posedge Clk);
      model_edge(r, l, e, sg);
      @(negedge Clk);
      check("queue", queue, m_q);
      check("C", C, (m_q != 0));
      check("err", err, m_err);
      check("fault", fault, m_fault);
   endtask

   task automatic run(input bit l, input bit e, input bit sg, input bit r, input int n);
      for (int i = 0; i < n; i++) tick(l, e, sg, r);
   endtask

   task automatic vehicle(input bit is_exit);
      if (is_exit) begin run(0, 1, 0, 0, 4); run(0, 0, 0, 0, 5); end
      else         begin run(1, 0, 0, 0, 4); run(0, 0, 0, 0, 5); end
   endtask

   initial begin
      loop_in = 0; exit_in = 0; SG = 0; reset = 1;
      @(negedge Clk);

      // 1: latency from first sampled edge
      run(0, 0, 0, 1, 2);
      check("rst_queue", queue, 0);
      check("rst_C", C, 0);
      for (int i = 0; i < 10; i++) begin
         tick(1, 0, 0, 0);
         check("t1_C_edge", C, (i >= 4));
      end
      run(0, 0, 0, 0, 6);
      check("t1_queue", queue, 1);

      // 2: glitches on both loops
      run(0, 0, 0, 1, 1);
      run(1, 0, 0, 0, 2);
      run(0, 0, 0, 0, 6);
      check("t2_arr_glitch", queue, 0);
      vehicle(0);
      run(0, 1, 0, 0, 2);
      run(0, 0, 0, 0, 6);
      check("t2_ext_glitch", queue, 1);

      // 3: three in, three out
      run(0, 0, 0, 1, 1);
      for (int i = 1; i <= 3; i++) begin
         vehicle(0);
         check("t3_up", queue, i);
      end
      for (int i = 2; i >= 0; i--) begin
         vehicle(1);
         check("t3_down", queue, i);
      end
      check("t3_C", C, 0);
      check("t3_err", err, 0);

      // 4: coincident arrival and exit
      vehicle(0); vehicle(0);
      run(1, 1, 0, 0, 4);
      run(0, 0, 0, 0, 5);
      check("t4_queue", queue, 2);
      check("t4_err", err, 0);

      // 5: saturation and underflow
      run(0, 0, 0, 1, 1);
      for (int i = 0; i < 15; i++) vehicle(0);
      check("t5_15_err", err, 0);
      vehicle(0);
      check("t5_sat_queue", queue, 15);
      check("t5_sat_err", err, 1);
      run(0, 0, 0, 1, 1);
      vehicle(1);
      check("t5_under_queue", queue, 0);
      check("t5_under_err", err, 1);
      run(0, 0, 0, 1, 1);
      check("t5_rst_err", err, 0);

      // 6: stuck loop with SG held
      vehicle(0); vehicle(0);
      run(0, 0, 1, 0, 40);
`ifdef TRAFFIC_STUCK_CLR_EN
      check("t6_queue", queue, 0);
      check("t6_fault", fault, 1);
`else
      check("t6_queue", queue, 2);
      check("t6_fault", fault, 0);
`endif
      run(0, 0, 0, 0, 2);

      // 7: reset while rise is pending
      run(0, 0, 0, 1, 1);
      run(1, 0, 0, 0, 3);
      run(1, 0, 0, 1, 1);
      check("t7_after_rst", queue, 0);
      run(1, 0, 0, 0, 4);
      check("t7_not_yet", queue, 0);
      tick(1, 0, 0, 0);
      check("t7_counted", queue, 1);
      run(0, 0, 0, 0, 5);

      // Random segments of held levels
      run(0, 0, 0, 1, 1);
      for (int k = 0; k < 300; k++) begin
         bit l, e, sg, r;
         int n;
         l  = ($urandom_range(0, 99) < 45);
         e  = ($urandom_range(0, 99) < 35);
         sg = ($urandom_range(0, 99) < 70);
         r  = ($urandom_range(0, 99) < 2);
         n  = $urandom_range(1, 6);
         run(l, e, sg, r, r ? 1 : n);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
